// File: rtl/ml_regression_stream_pkg.sv
// Shared definitions for the streaming linear-regression engines:
// default widths, FSM state encoding and the round/saturate helper.
package ml_regression_pkg;

   localparam int DEF_N_FEAT     = 7;
   localparam int DEF_LANE_W     = 16;
   localparam int DEF_COEF_W     = 16;
   localparam int DEF_ACC_W      = 40;
   localparam int DEF_FRAC_SHIFT = 8;
   localparam int DEF_OUT_W      = 16;
   localparam int COEF_ADDR_W    = 5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MAC   = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   // Round half toward +inf, drop frac_shift fractional bits, then either
   // clamp to the signed out_w range (sat=1, ovf flags a clamp) or leave the
   // value for the caller to truncate (sat=0, ovf stays 0).
   function automatic logic signed [63:0] round_sat(
      input  logic signed [63:0] acc,
      input  int                 frac_shift,
      input  int                 out_w,
      input  bit                 sat,
      output logic               ovf
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r   = (acc + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
      hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (out_w - 1));
      ovf = 1'b0;
      if (sat) begin
         if (r > hi) begin
            r   = hi;
            ovf = 1'b1;
         end else if (r < lo) begin
            r   = lo;
            ovf = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ml_regression_stream_if.sv
// Feature-in / prediction-out stream bundle for ml_regression_stream.
// Both directions use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high (and the engine's enb is high);
// valid never waits on ready, and ready on din depends on engine state only.
interface ml_regression_stream_if
   import ml_regression_pkg::*;
#(
   parameter int N_FEAT = DEF_N_FEAT,
   parameter int LANE_W = DEF_LANE_W,
   parameter int OUT_W  = DEF_OUT_W
);
   logic [N_FEAT*LANE_W-1:0] din;
   logic                     din_valid;
   logic                     din_ready;
   logic signed [OUT_W-1:0]  dout;
   logic                     dout_valid;
   logic                     dout_ready;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid
   );
endinterface

// File: rtl/ml_regression_stream_mac_unit.sv
// Registered signed accumulator: load seeds it with the bias, acc_en adds
// one full-precision product of an unsigned feature and a signed weight.
module ml_mac_unit
   import ml_regression_pkg::*;
#(
   parameter int LANE_W = DEF_LANE_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic signed [COEF_W-1:0] load_val,
   input  logic                     acc_en,
   input  logic [LANE_W-1:0]        x,
   input  logic signed [COEF_W-1:0] w,
   output logic signed [ACC_W-1:0]  acc
);
   localparam int PROD_W = LANE_W + COEF_W + 1;

   logic signed [PROD_W-1:0] prod;

   // Feature is zero-extended by one bit so the product stays signed.
   assign prod = PROD_W'($signed({1'b0, x})) * PROD_W'(w);

   // Seed with the bias or accumulate one product.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else if (load) begin
         acc <= ACC_W'(load_val);
      end else if (acc_en) begin
         acc <= acc + ACC_W'(prod);
      end
   end
endmodule

// File: rtl/ml_regression_stream.sv
// Streaming linear-regression engine: ypred = round((bias + sum w*x) >>> FRAC_SHIFT).
// One shared MAC iterates over N_FEAT lanes. Define ML_REGRESSION_SAT_EN to
// clamp the result to the OUT_W range (with an ovf pulse); otherwise the
// result wraps to its low OUT_W bits and ovf stays 0.
module ml_regression_stream
   import ml_regression_pkg::*;
#(
   parameter int N_FEAT     = DEF_N_FEAT,
   parameter int LANE_W     = DEF_LANE_W,
   parameter int COEF_W     = DEF_COEF_W,
   parameter int ACC_W      = DEF_ACC_W,
   parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
   parameter int OUT_W      = DEF_OUT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enb,
   ml_regression_stream_if.slave    strm,
   input  logic                     coef_we,
   input  logic [COEF_ADDR_W-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic                     busy,
   output logic                     ovf,
   output logic [1:0]               dbg_state
);
   localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(N_FEAT - 1);
   localparam logic [COEF_ADDR_W-1:0] BIAS_ADDR = COEF_ADDR_W'(N_FEAT);
`ifdef ML_REGRESSION_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [1:0]                state_q;
   logic [IDX_W-1:0]          idx_q;
   logic [N_FEAT*LANE_W-1:0]  din_q;
   logic signed [COEF_W-1:0]  w_q [N_FEAT];
   logic signed [COEF_W-1:0]  bias_q;
   logic signed [OUT_W-1:0]   dout_q;
   logic                      dout_valid_q;
   logic                      ovf_q;

   logic                      accept;
   logic                      coef_wr;
   logic                      acc_en;
   logic signed [COEF_W-1:0]  bias_eff;
   logic signed [COEF_W-1:0]  w_cur;
   logic [LANE_W-1:0]         x_cur;
   logic signed [ACC_W-1:0]   acc;
   logic signed [63:0]        rnd_val;
   logic                      rnd_ovf;
   logic                      unused_rnd_hi;

   assign accept  = enb && (state_q == ST_IDLE) && strm.din_valid;
   assign coef_wr = enb && (state_q == ST_IDLE) && coef_we;
   assign acc_en  = enb && (state_q == ST_MAC);

   // A bias write in the accept cycle must reach the accumulator seed.
   always_comb begin
      bias_eff = bias_q;
      if (coef_wr && (coef_addr == BIAS_ADDR)) bias_eff = coef_wdata;
   end

   // Lane and weight selected by the MAC iteration index.
   always_comb begin
      x_cur = din_q[idx_q*LANE_W +: LANE_W];
      w_cur = w_q[idx_q];
   end

   ml_mac_unit #(
      .LANE_W (LANE_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .load_val (bias_eff),
      .acc_en   (acc_en),
      .x        (x_cur),
      .w        (w_cur),
      .acc      (acc)
   );

   // Round (and optionally clamp) the finished accumulator.
   always_comb begin
      rnd_val = round_sat(64'(acc), FRAC_SHIFT, OUT_W, SAT_EN, rnd_ovf);
   end
   assign unused_rnd_hi = ^rnd_val[63:OUT_W];

   // Coefficient register file; writes only land while idle and enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_FEAT; i++) w_q[i] <= '0;
         bias_q <= '0;
      end else begin
         for (int i = 0; i < N_FEAT; i++) begin
            if (coef_wr && (coef_addr == COEF_ADDR_W'(i))) w_q[i] <= coef_wdata;
         end
         if (coef_wr && (coef_addr == BIAS_ADDR)) bias_q <= coef_wdata;
      end
   end

   // Control FSM: IDLE -> MAC x N_FEAT -> ROUND -> OUT (wait for dout_ready).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         din_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else if (enb) begin
         case (state_q)
            ST_IDLE: begin
               if (strm.din_valid) begin
                  din_q   <= strm.din;
                  idx_q   <= '0;
                  state_q <= ST_MAC;
               end
            end
            ST_MAC: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_q <= ST_ROUND;
            end
            ST_ROUND: begin
               dout_q       <= rnd_val[OUT_W-1:0];
               dout_valid_q <= 1'b1;
               ovf_q        <= rnd_ovf;
               state_q      <= ST_OUT;
            end
            ST_OUT: begin
               ovf_q <= 1'b0;
               if (strm.dout_ready) begin
                  dout_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign strm.din_ready  = (state_q == ST_IDLE);
   assign strm.dout       = dout_q;
   assign strm.dout_valid = dout_valid_q;
   assign busy            = (state_q != ST_IDLE);
   assign ovf             = ovf_q;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_ml_regression_stream.sv
// Directed + randomized bench for ml_regression_stream at default parameters.
// Expected predictions come from an arithmetic model of the regression
// formula held in the bench (w_m/bias_m mirror only legal coefficient writes).
module tb_ml_regression_stream;
   localparam int NF = 7;
   localparam int LW = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        enb;
   logic        coef_we;
   logic [4:0]  coef_addr;
   logic [15:0] coef_wdata;
   logic        busy;
   logic        ovf;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int w_m [NF];
   int bias_m;

   ml_regression_stream_if #(.N_FEAT(NF), .LANE_W(LW), .OUT_W(16)) sif ();

   ml_regression_stream dut (
      .clk        (clk),
      .reset      (reset),
      .enb        (enb),
      .strm       (sif),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .busy       (busy),
      .ovf        (ovf),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NF*LW-1:0] pack(input int xs[NF]);
      logic [NF*LW-1:0] d;
      d = '0;
      for (int i = 0; i < NF; i++) d[i*LW +: LW] = 16'(xs[i]);
      return d;
   endfunction

   function automatic int rand_coef();
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      return int'($signed(v));
   endfunction

   // Prediction straight from the formula: floor((acc + 128) / 256), then
   // clamp or wrap to 16 signed bits.
   function automatic void model(input int xs[NF], output int r, output int ov);
      longint acc;
      longint num;
      longint q;
`ifndef ML_REGRESSION_SAT_EN
      logic [63:0] qb;
`endif
      acc = bias_m;
      for (int i = 0; i < NF; i++) acc += longint'(xs[i]) * longint'(w_m[i]);
      num = acc + 128;
      q   = num / 256;
      if ((num % 256) != 0 && num < 0) q = q - 1;
      ov = 0;
`ifdef ML_REGRESSION_SAT_EN
      if (q > 32767) begin
         q  = 32767;
         ov = 1;
      end else if (q < -32768) begin
         q  = -32768;
         ov = 1;
      end
      r = int'(q);
`else
      qb = q;
      r  = int'($signed(qb[15:0]));
`endif
   endfunction

   task automatic coef_write(input int addr, input int val);
      coef_we    = 1'b1;
      coef_addr  = 5'(addr);
      coef_wdata = 16'(val);
      tick();
      coef_we = 1'b0;
      if (addr < NF) w_m[addr] = val;
      else if (addr == NF) bias_m = val;
   endtask

   // One full transaction: accept, optional enb freeze (3 cycles) at a given
   // cycle count, optional coefficient write during MAC, optional output hold.
   task automatic do_txn(input string tag, input int xs[NF], input int hold,
                         input int freeze_at, input bit mac_wr, input int exp_lat,
                         output int dval);
      int exp_r, exp_ov, lat, oval, obs;
      bit busy_ok, hold_ok, post_ok;
      model(xs, exp_r, exp_ov);
      sif.din       = pack(xs);
      sif.din_valid = 1'b1;
      tick();
      sif.din_valid = 1'b0;
      coef_we       = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (sif.dout_valid !== 1'b1 && lat < 60) begin
         if (lat == freeze_at) begin
            enb = 1'b0;
            repeat (3) begin
               tick();
               lat++;
               if (busy !== 1'b1 || sif.dout_valid !== 1'b0) busy_ok = 1'b0;
            end
            enb = 1'b1;
         end
         coef_we = (mac_wr && lat == 2);
         tick();
         coef_we = 1'b0;
         lat++;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      dval = sif.dout;
      oval = ovf;
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         sif.din       = ~pack(xs);
         sif.din_valid = 1'b1;
         tick();
         obs = sif.dout;
         if (obs != dval || sif.dout_valid !== 1'b1 || sif.din_ready !== 1'b0 ||
             busy !== 1'b1) hold_ok = 1'b0;
      end
      sif.din_valid  = 1'b0;
      sif.dout_ready = 1'b1;
      tick();
      sif.dout_ready = 1'b0;
      post_ok = (sif.dout_valid === 1'b0 && busy === 1'b0 &&
                 sif.din_ready === 1'b1 && ovf === 1'b0);
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".dout"}, dval, exp_r);
      chk({tag, ".ovf"}, oval, exp_ov);
      chk({tag, ".busy"}, busy_ok, 1);
      if (hold > 0) chk({tag, ".hold"}, hold_ok, 1);
      chk({tag, ".handoff"}, post_ok, 1);
   endtask

   initial begin
      int xs [NF];
      int r1, r2, rz;

      reset          = 1'b1;
      enb            = 1'b1;
      coef_we        = 1'b0;
      coef_addr      = '0;
      coef_wdata     = '0;
      sif.din        = '0;
      sif.din_valid  = 1'b0;
      sif.dout_ready = 1'b0;
      for (int i = 0; i < NF; i++) w_m[i] = 0;
      bias_m = 0;
      repeat (3) tick();
      chk("reset.dout", sif.dout, 0);
      chk("reset.dout_valid", sif.dout_valid, 0);
      chk("reset.ovf", ovf, 0);
      chk("reset.din_ready", sif.din_ready, 1);
      chk("reset.busy", busy, 0);
      reset = 1'b0;
      tick();

      // Coefficients come up zero after reset.
      for (int i = 0; i < NF; i++) xs[i] = $urandom_range(0, 65535);
      do_txn("zero_coef", xs, 0, -1, 1'b0, 8, rz);
      chk("zero_coef.value", rz, 0);

      // Unit weights.
      for (int i = 0; i < NF; i++) coef_write(i, 256);
      coef_write(NF, 0);
      for (int i = 0; i < NF; i++) xs[i] = i + 1;
      do_txn("unit", xs, 0, -1, 1'b0, 8, r1);
      chk("unit.value", r1, 28);

      // Negative weight and rounding edge cases.
      for (int i = 1; i < NF; i++) coef_write(i, 0);
      coef_write(0, -256);
      for (int i = 1; i < NF; i++) xs[i] = $urandom_range(0, 65535);
      xs[0] = 1000;
      do_txn("neg", xs, 0, -1, 1'b0, 8, r1);
      chk("neg.value", r1, -1000);
      coef_write(0, 128);
      xs[0] = 1;
      do_txn("half_up", xs, 0, -1, 1'b0, 8, r1);
      chk("half_up.value", r1, 1);
      coef_write(0, -128);
      do_txn("neg_half", xs, 0, -1, 1'b0, 8, r1);
      chk("neg_half.value", r1, 0);

      // Largest product: clamps or wraps depending on the build.
      coef_write(0, 32767);
      xs[0] = 65535;
      do_txn("sat", xs, 0, -1, 1'b0, 8, r1);

      // Backpressure and enb freeze with random coefficients.
      for (int i = 0; i < NF; i++) coef_write(i, $urandom_range(0, 600) - 300);
      coef_write(NF, $urandom_range(0, 2000) - 1000);
      for (int i = 0; i < NF; i++) xs[i] = $urandom_range(0, 65535);
      do_txn("backpressure", xs, 5, -1, 1'b0, 8, r1);
      do_txn("freeze", xs, 0, 3, 1'b0, 11, r2);
      chk("freeze.same_result", r2, r1);

      // Coefficient write during MAC is dropped (model keeps old w3).
      coef_addr  = 5'd3;
      coef_wdata = 16'd512;
      do_txn("mac_write", xs, 0, -1, 1'b1, 8, r1);

      // Bias write offsets the next result by +5.
      for (int i = 0; i < NF; i++) coef_write(i, 256);
      coef_write(NF, 0);
      for (int i = 0; i < NF; i++) xs[i] = $urandom_range(0, 100);
      do_txn("bias_before", xs, 0, -1, 1'b0, 8, r1);
      coef_write(NF, 1280);
      do_txn("bias_after", xs, 0, -1, 1'b0, 8, r2);
      chk("bias.offset", r2 - r1, 5);

      // Out-of-range address is ignored (model not updated).
      coef_we    = 1'b1;
      coef_addr  = 5'd20;
      coef_wdata = 16'd999;
      tick();
      coef_we = 1'b0;
      do_txn("bad_addr", xs, 0, -1, 1'b0, 8, r1);
      chk("bad_addr.value", r1, r2);

      // Write landing in the same cycle as the accept is used immediately.
      coef_we    = 1'b1;
      coef_addr  = 5'd0;
      coef_wdata = 16'd1024;
      w_m[0]     = 1024;
      do_txn("same_cycle_w", xs, 0, -1, 1'b0, 8, r1);
      coef_we    = 1'b1;
      coef_addr  = 5'(NF);
      coef_wdata = 16'hFD00;
      bias_m     = -768;
      do_txn("same_cycle_bias", xs, 0, -1, 1'b0, 8, r1);

      // Reset in the middle of MAC.
      sif.din       = pack(xs);
      sif.din_valid = 1'b1;
      tick();
      sif.din_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NF; i++) w_m[i] = 0;
      bias_m = 0;
      chk("midreset.busy", busy, 0);
      chk("midreset.din_ready", sif.din_ready, 1);
      chk("midreset.dout_valid", sif.dout_valid, 0);
      chk("midreset.dout", sif.dout, 0);
      for (int i = 0; i < NF; i++) xs[i] = $urandom_range(0, 65535);
      do_txn("after_reset", xs, 0, -1, 1'b0, 8, r1);
      chk("after_reset.value", r1, 0);

      // Random transactions with random coefficient writes (some illegal).
      for (int t = 0; t < 12; t++) begin
         int a, fz;
         repeat (3) begin
            a = $urandom_range(0, 9);
            if (a > NF) a = $urandom_range(8, 31);
            coef_write(a, rand_coef());
         end
         for (int i = 0; i < NF; i++) xs[i] = $urandom_range(0, 65535);
         fz = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
         do_txn("random", xs, $urandom_range(0, 3), fz, 1'b0,
                (fz >= 0) ? 11 : 8, r1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
